// File: rtl/seq_tx.sv
// -----------------------------------------------------------------------------
// seq_tx : serial pattern burst transmitter
//
// Sends a fixed PAT_W-bit PATTERN, MSB first, as a burst of frames. Frames are
// separated by GAP idle cycles. A burst holds the number of frames given on
// count when start is accepted, or runs until stop when count is 0. A stop
// request always lets the current frame finish.
//
// Parameters:
//   PAT_W    pattern length in bits (2..16)
//   PATTERN  transmitted pattern, MSB sent first
//   GAP      idle cycles between frames (0..15)
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-low
//   start      in   begin a burst (honoured in IDLE only)
//   count[3:0] in   frames per burst, latched at start (0 = until stop)
//   stop       in   end the burst after the current frame
//   out        out  serial data bit (registered)
//   out_valid  out  out carries a pattern bit
//   busy       out  high in SEND and GAP
//   done       out  one-cycle pulse at burst end
//   state[1:0] out  current FSM state (IDLE=0 SEND=1 GAP=2 DONE=3)
//   frame_cnt[7:0] out  saturating completed-frame count
//                       (present only with SEQ_TX_FRAME_CNT_EN defined)
//
// Handshake: start and stop are level-sampled request strobes with no ready
// return; start is taken only on a clock edge where state is IDLE, and stop is
// remembered in a sticky flag until the burst returns to IDLE.
//
// Optional feature macro: SEQ_TX_FRAME_CNT_EN
// -----------------------------------------------------------------------------
module seq_tx #(
   parameter int               PAT_W   = 5,
   parameter logic [PAT_W-1:0] PATTERN = 5'b10010,
   parameter int               GAP     = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] count,
   input  logic       stop,
   output logic       out,
   output logic       out_valid,
   output logic       busy,
   output logic       done,
`ifdef SEQ_TX_FRAME_CNT_EN
   output logic [7:0] frame_cnt,
`endif
   output logic [1:0] state
);

   localparam int               IDX_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(PAT_W - 1);
   localparam logic [3:0]       GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_GAP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [3:0]       gcnt_q, gcnt_d;
   logic             stop_q, stop_d;
   logic             out_q, out_valid_q, busy_q, done_q;
   logic             frame_end;
   logic             stop_pend;

   // Stop seen this cycle counts as pending so a late stop is still honoured
   // at the frame/gap boundary it coincides with.
   assign stop_pend = stop_q | stop;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      gcnt_d    = gcnt_q;
      frame_end = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SEND;
               idx_d   = IDX_MAX;
               cnt_d   = count;
            end
         end
         S_SEND: begin
            if (idx_q == '0) begin
               frame_end = 1'b1;
               if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
               // cnt_q==1 means this was the last frame of a counted burst;
               // cnt_q==0 is continuous mode and never exhausts.
               if (cnt_q == 4'd1 || stop_pend) begin
                  state_d = S_DONE;
               end else if (GAP == 0) begin
                  state_d = S_SEND;
                  idx_d   = IDX_MAX;
               end else begin
                  state_d = S_GAP;
                  gcnt_d  = GAP_LAST;
               end
            end else begin
               idx_d = idx_q - 1'b1;
            end
         end
         S_GAP: begin
            if (gcnt_q == 4'd0) begin
               if (stop_pend) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_SEND;
                  idx_d   = IDX_MAX;
               end
            end else begin
               gcnt_d = gcnt_q - 4'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Sticky stop: captured while busy, or together with an accepted start.
      if (state_d == S_IDLE) begin
         stop_d = 1'b0;
      end else if (stop && (state_q == S_SEND || state_q == S_GAP || state_q == S_IDLE)) begin
         stop_d = 1'b1;
      end else begin
         stop_d = stop_q;
      end
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         idx_q       <= IDX_MAX;
         cnt_q       <= 4'd0;
         gcnt_q      <= 4'd0;
         stop_q      <= 1'b0;
         out_q       <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         gcnt_q      <= gcnt_d;
         stop_q      <= stop_d;
         out_q       <= (state_d == S_SEND) ? PATTERN[idx_d] : 1'b0;
         out_valid_q <= (state_d == S_SEND);
         busy_q      <= (state_d == S_SEND) || (state_d == S_GAP);
         done_q      <= (state_d == S_DONE);
      end
   end

`ifdef SEQ_TX_FRAME_CNT_EN
   logic [7:0] frame_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         frame_cnt_q <= 8'd0;
      end else if (frame_end && frame_cnt_q != 8'hFF) begin
         frame_cnt_q <= frame_cnt_q + 8'd1;
      end
   end

   assign frame_cnt = frame_cnt_q;
`endif

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign state     = state_q;

endmodule

// File: tb/tb_seq_tx.sv
// -----------------------------------------------------------------------------
// tb_seq_tx : directed self-checking bench for seq_tx (default parameters).
// Inputs change 1 time unit after a rising edge; outputs are checked there too,
// so every check sees the values registered on the preceding edge.
// -----------------------------------------------------------------------------
module tb_seq_tx;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] count;
   logic       stop;
   logic       out;
   logic       out_valid;
   logic       busy;
   logic       done;
   logic [1:0] state;
`ifdef SEQ_TX_FRAME_CNT_EN
   logic [7:0] frame_cnt;
`endif

   int tests;
   int fails;

   // Expected pattern written out by hand, MSB sent first.
   logic [4:0] pat;

   seq_tx dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .count     (count),
      .stop      (stop),
      .out       (out),
      .out_valid (out_valid),
      .busy      (busy),
      .done      (done),
`ifdef SEQ_TX_FRAME_CNT_EN
      .frame_cnt (frame_cnt),
`endif
      .state     (state)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Check all outputs at once against an expected tuple.
   task automatic chk_all(input string tag, input logic e_out, input logic e_vld,
                          input logic e_busy, input logic e_done, input logic [1:0] e_st);
      chk({tag, ".out"},       {7'd0, out},       {7'd0, e_out});
      chk({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, e_vld});
      chk({tag, ".busy"},      {7'd0, busy},      {7'd0, e_busy});
      chk({tag, ".done"},      {7'd0, done},      {7'd0, e_done});
      chk({tag, ".state"},     {6'd0, state},     {6'd0, e_st});
   endtask

   // Check pattern bits first..last of a frame, advancing one cycle per bit.
   task automatic frame_bits(input string tag, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         chk_all($sformatf("%s.bit%0d", tag, i), pat[4-i], 1'b1, 1'b1, 1'b0, 2'd1);
         tick();
      end
   endtask

   task automatic gap_cycles(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk_all($sformatf("%s.gap%0d", tag, i), 1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
         tick();
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      pat   = 5'b10010;
      rst   = 1'b0;
      start = 1'b1;
      count = 4'd1;
      stop  = 1'b0;

      // Reset held 3 cycles with start high: everything stays idle.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_all($sformatf("reset%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      end
      rst   = 1'b1;
      start = 1'b0;
      tick();
      chk_all("idle_after_reset", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

      // count=1: one frame, done right after, start in DONE ignored.
      count = 4'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      count = 4'd7;                      // change while busy has no effect
      frame_bits("c1", 0, 4);
      chk_all("c1.done", 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
      start = 1'b1;                      // ignored in DONE
      tick();
      start = 1'b0;
      chk_all("c1.idle", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      tick();
      chk_all("c1.idle2", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

      // count=2: frame, two gap cycles, frame, done.
      count = 4'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      count = 4'd0;
      frame_bits("c2f1", 0, 4);
      gap_cycles("c2");
      frame_bits("c2f2", 0, 4);
      chk_all("c2.done", 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
      tick();
      chk_all("c2.idle", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

      // count=0 continuous; stop during bit 1 of frame 3 -> exactly 3 frames.
      count = 4'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      frame_bits("c0f1", 0, 4);
      gap_cycles("c0g1");
      frame_bits("c0f2", 0, 4);
      gap_cycles("c0g2");
      frame_bits("c0f3", 0, 0);
      stop = 1'b1;
      frame_bits("c0f3", 1, 1);
      stop = 1'b0;
      frame_bits("c0f3", 2, 4);
      chk_all("c0.done", 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
      tick();
      chk_all("c0.idle", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

      // start and stop together in IDLE: exactly one frame even with count=0.
      count = 4'd0;
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      frame_bits("ss", 0, 4);
      chk_all("ss.done", 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
      tick();
      chk_all("ss.idle", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

      // stop during a gap: next frame not started.
      count = 4'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      frame_bits("sg", 0, 4);
      stop = 1'b1;
      gap_cycles("sg");
      stop = 1'b0;
      chk_all("sg.done", 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
      tick();
      chk_all("sg.idle", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

      // Re-pulse start mid-frame: frame and burst length unaffected.
      count = 4'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      frame_bits("rp", 0, 1);
      start = 1'b1;
      frame_bits("rp", 2, 2);
      start = 1'b0;
      frame_bits("rp", 3, 4);
      chk_all("rp.done", 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
      tick();
      chk_all("rp.idle", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

      // Next burst, reset at the third bit: immediate abort, no done pulse.
      count = 4'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      frame_bits("rs", 0, 1);
      chk_all("rs.bit2", pat[2], 1'b1, 1'b1, 1'b0, 2'd1);
      rst = 1'b0;
      tick();
      chk_all("rs.reset", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      rst = 1'b1;
      tick();
      chk_all("rs.after", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
      tick();
      chk_all("rs.after2", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

`ifdef SEQ_TX_FRAME_CNT_EN
      // Two bursts of 3 frames after reset -> 6 completed frames.
      chk("fc.reset", frame_cnt, 8'd0);
      for (int b = 0; b < 2; b++) begin
         count = 4'd3;
         start = 1'b1;
         tick();
         start = 1'b0;
         frame_bits($sformatf("fc%0df1", b), 0, 4);
         gap_cycles($sformatf("fc%0dg1", b));
         frame_bits($sformatf("fc%0df2", b), 0, 4);
         gap_cycles($sformatf("fc%0dg2", b));
         frame_bits($sformatf("fc%0df3", b), 0, 4);
         chk_all($sformatf("fc%0d.done", b), 1'b0, 1'b0, 1'b0, 1'b1, 2'd3);
         tick();
      end
      chk("fc.six", frame_cnt, 8'd6);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("fc.cleared", frame_cnt, 8'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
